// File: rtl/wb_retire_stage_pkg.sv
// Shared widths and helpers for the write-back / retire stage of the turbo pipeline.
// Bus widths below correspond to the default parameter set of wb_retire_stage.
package wb_retire_stage_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int PC_W_DEF     = 32;
  localparam int RA_W_DEF     = 5;
  localparam int TQ_DEPTH_DEF = 4;
  localparam int CNT_W_DEF    = 32;

  localparam int MEM_TO_WB_BUS_WD = PC_W_DEF + 1 + RA_W_DEF + XLEN_DEF;
  localparam int WB_TO_RF_BUS_WD  = 1 + RA_W_DEF + XLEN_DEF;
  localparam int WB_FW_BUS_WD     = 1 + RA_W_DEF + XLEN_DEF;
  localparam int WB_TRACE_WD      = 1 + RA_W_DEF + XLEN_DEF + PC_W_DEF;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Retire trace FIFO: power-of-two depth, wrapping pointers, synchronous reset that
// also clears the storage so the head slot reads zero after reset.
module wb_trace_fifo
  import wb_retire_stage_pkg::*;
#(
  parameter int W     = WB_TRACE_WD,
  parameter int DEPTH = TQ_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/wb_retire_stage.sv
// Write-back stage: holds one MEM result, commits it to the RF and the trace FIFO
// when the FIFO has room, forwards it to ID, and counts retire/write/stall events.
module wb_retire_stage
  import wb_retire_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int RA_W     = RA_W_DEF,
  parameter int TQ_DEPTH = TQ_DEPTH_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          MEM_to_WB_valid,
  input  logic [PC_W+1+RA_W+XLEN-1:0]   MEM_to_WB_bus,
  output logic                          WB_ready,
  output logic [1+RA_W+XLEN-1:0]        WB_to_RF_bus,
  output logic [1+RA_W+XLEN-1:0]        WB_fw_bus,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [1+RA_W+XLEN+PC_W-1:0]   trace_data,
  output logic [CNT_W-1:0]              Valid_Inst_cnt,
  output logic [CNT_W-1:0]              RF_Write_cnt,
  output logic [CNT_W-1:0]              WB_Stall_cnt
);

  localparam int BUS_W = PC_W + 1 + RA_W + XLEN;
  localparam int TR_W  = 1 + RA_W + XLEN + PC_W;

  logic [BUS_W-1:0] bus_reg;
  logic             wb_work;
  logic [PC_W-1:0]  wb_pc;
  logic             wb_wen;
  logic [RA_W-1:0]  wb_waddr;
  logic [XLEN-1:0]  wb_wdata;
  logic             pop;
  logic             space;
  logic             commit;
  logic             tq_full;
  logic             tq_empty;

  assign wb_pc    = bus_reg[XLEN+RA_W+1 +: PC_W];
  assign wb_wen   = bus_reg[XLEN+RA_W];
  assign wb_waddr = bus_reg[XLEN +: RA_W];
  assign wb_wdata = bus_reg[XLEN-1:0];

  // Ready only depends on trace_ready through the pop path, keeping the loop shallow.
  assign pop      = trace_valid & trace_ready;
  assign space    = ~tq_full | pop;
  assign commit   = wb_work & space;
  assign WB_ready = ~wb_work | commit;

  assign WB_to_RF_bus = {commit & wb_wen, wb_waddr, wb_wdata};
  assign WB_fw_bus    = {wb_work & wb_wen, wb_waddr, wb_wdata};
  assign trace_valid  = ~tq_empty;

  wb_trace_fifo #(
    .W    (TR_W),
    .DEPTH(TQ_DEPTH)
  ) u_trace_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (commit),
    .pop  (pop),
    .wdata({wb_wen, wb_waddr, wb_wdata, wb_pc}),
    .rdata(trace_data),
    .full (tq_full),
    .empty(tq_empty)
  );

  // Stage register keeps its last contents while idle; only the valid bit clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_work <= 1'b0;
      bus_reg <= '0;
    end else if (WB_ready) begin
      wb_work <= MEM_to_WB_valid;
      if (MEM_to_WB_valid) bus_reg <= MEM_to_WB_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Valid_Inst_cnt <= '0;
      RF_Write_cnt   <= '0;
      WB_Stall_cnt   <= '0;
    end else begin
      if (commit)           Valid_Inst_cnt <= Valid_Inst_cnt + CNT_W'(1);
      if (commit && wb_wen) RF_Write_cnt   <= RF_Write_cnt + CNT_W'(1);
      if (wb_work && !commit) WB_Stall_cnt <= WB_Stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and resets.
module tb_wb_retire_stage;

  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int RA_W  = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            wen;
    logic [RA_W-1:0] waddr;
    logic [XLEN-1:0] wdata;
  } inst_t;

  logic                        clk;
  logic                        rst;
  logic                        MEM_to_WB_valid;
  logic [PC_W+1+RA_W+XLEN-1:0] MEM_to_WB_bus;
  logic                        WB_ready;
  logic [1+RA_W+XLEN-1:0]      WB_to_RF_bus;
  logic [1+RA_W+XLEN-1:0]      WB_fw_bus;
  logic                        trace_valid;
  logic                        trace_ready;
  logic [1+RA_W+XLEN+PC_W-1:0] trace_data;
  logic [CNT_W-1:0]            Valid_Inst_cnt;
  logic [CNT_W-1:0]            RF_Write_cnt;
  logic [CNT_W-1:0]            WB_Stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  wb_retire_stage #(
    .XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .TQ_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .MEM_to_WB_valid(MEM_to_WB_valid), .MEM_to_WB_bus(MEM_to_WB_bus),
    .WB_ready(WB_ready), .WB_to_RF_bus(WB_to_RF_bus), .WB_fw_bus(WB_fw_bus),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .Valid_Inst_cnt(Valid_Inst_cnt), .RF_Write_cnt(RF_Write_cnt), .WB_Stall_cnt(WB_Stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one held instruction, a bounded queue of retired entries, plain counters.
  bit    m_live = 0;
  bit    m_wb_v;
  inst_t m_bus;
  inst_t q[$];
  int    m_vic, m_rfw, m_stall;

  function automatic logic [69:0] trace_of(input inst_t i);
    return {i.wen, i.waddr, i.wdata, i.pc};
  endfunction

  function automatic inst_t mk(input logic [31:0] pc, input logic wen,
                               input logic [4:0] waddr, input logic [31:0] wdata);
    inst_t i;
    i.pc = pc; i.wen = wen; i.waddr = waddr; i.wdata = wdata;
    return i;
  endfunction

  function automatic inst_t jinst(input int k);
    return mk(32'h200 + 32'(4 * k), 1'b1, 5'(k + 8), 32'hB0 + 32'(k));
  endfunction

  always @(posedge clk) begin
    bit p, c, r;
    if (rst) begin
      m_live = 1; m_wb_v = 0; m_bus = '0; q.delete();
      m_vic = 0; m_rfw = 0; m_stall = 0;
    end else if (m_live) begin
      p = (q.size() != 0) && trace_ready;
      c = m_wb_v && (q.size() < DEPTH || p);
      r = !m_wb_v || c;
      if (p) void'(q.pop_front());
      if (c) begin
        q.push_back(m_bus);
        m_vic++;
        if (m_bus.wen) m_rfw++;
      end
      if (m_wb_v && !c) m_stall++;
      if (r) begin
        m_wb_v = MEM_to_WB_valid;
        if (MEM_to_WB_valid) m_bus = MEM_to_WB_bus;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Every cycle once the model has seen a reset edge, the outputs must follow the model.
  always @(negedge clk) begin
    bit e_pop, e_commit;
    if (m_live) begin
      e_pop    = (q.size() != 0) && trace_ready;
      e_commit = m_wb_v && (q.size() < DEPTH || e_pop);
      checkOutput("m_ready", WB_ready, !m_wb_v || e_commit);
      checkOutput("m_rf_bus", WB_to_RF_bus, {e_commit & m_bus.wen, m_bus.waddr, m_bus.wdata});
      checkOutput("m_fw_bus", WB_fw_bus, {m_wb_v & m_bus.wen, m_bus.waddr, m_bus.wdata});
      checkOutput("m_trace_valid", trace_valid, q.size() != 0);
      if (q.size() != 0) checkOutput("m_trace_data", trace_data, trace_of(q[0]));
      checkOutput("m_vic", Valid_Inst_cnt, m_vic % 16);
      checkOutput("m_rfw", RF_Write_cnt, m_rfw % 16);
      checkOutput("m_stall", WB_Stall_cnt, m_stall % 16);
    end
  end

  task automatic applyStimulus(input logic v, input inst_t i, input logic tr);
    MEM_to_WB_valid = v;
    MEM_to_WB_bus   = i;
    trace_ready     = tr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    inst_t ri;
    int    bias;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    doReset();

    // Reset state
    checkOutput("rst_ready", WB_ready, 1);
    checkOutput("rst_tvalid", trace_valid, 0);
    checkOutput("rst_tdata", trace_data, 0);
    checkOutput("rst_rf_wen", WB_to_RF_bus[37], 0);
    checkOutput("rst_fw_valid", WB_fw_bus[37], 0);
    checkOutput("rst_cnts", {Valid_Inst_cnt, RF_Write_cnt, WB_Stall_cnt}, 0);

    // Three back-to-back instructions, consumer always ready
    applyStimulus(1'b1, mk(32'h100, 1'b1, 5'd1, 32'hA1), 1'b1); tick();
    checkOutput("t1_rf0", WB_to_RF_bus, {1'b1, 5'd1, 32'hA1});
    applyStimulus(1'b1, mk(32'h104, 1'b1, 5'd2, 32'hA2), 1'b1); tick();
    checkOutput("t1_rf1", WB_to_RF_bus, {1'b1, 5'd2, 32'hA2});
    checkOutput("t1_tr0", trace_data, {1'b1, 5'd1, 32'hA1, 32'h100});
    applyStimulus(1'b1, mk(32'h108, 1'b1, 5'd3, 32'hA3), 1'b1); tick();
    checkOutput("t1_rf2", WB_to_RF_bus, {1'b1, 5'd3, 32'hA3});
    checkOutput("t1_tr1", trace_data, {1'b1, 5'd2, 32'hA2, 32'h104});
    applyStimulus(1'b0, '0, 1'b1); tick();
    checkOutput("t1_tr2", trace_data, {1'b1, 5'd3, 32'hA3, 32'h108});
    checkOutput("t1_rf_idle", WB_to_RF_bus[37], 0);
    tick();
    checkOutput("t1_cnts", {Valid_Inst_cnt, RF_Write_cnt, WB_Stall_cnt}, {4'd3, 4'd3, 4'd0});
    checkOutput("t1_empty", trace_valid, 0);

    // FIFO fills with consumer blocked; fifth instruction stalls in WB
    applyStimulus(1'b0, '0, 1'b0); doReset();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, jinst(k), 1'b0); tick();
    end
    checkOutput("t2_ready", WB_ready, 0);
    checkOutput("t2_fw", WB_fw_bus, {1'b1, 5'd13, 32'hB5});
    applyStimulus(1'b1, jinst(6), 1'b0);
    tick(); tick(); tick();
    checkOutput("t2_stall", WB_Stall_cnt, 3);
    checkOutput("t2_vic", Valid_Inst_cnt, 4);
    // Full FIFO, pop and push in the same cycle
    applyStimulus(1'b1, jinst(6), 1'b1); tick();
    checkOutput("t3_head", trace_data, {1'b1, 5'd10, 32'hB2, 32'h208});
    checkOutput("t3_vic", Valid_Inst_cnt, 5);
    checkOutput("t3_ready", WB_ready, 1);
    applyStimulus(1'b0, '0, 1'b1);
    repeat (8) tick();
    checkOutput("t2_vic_all", Valid_Inst_cnt, 6);
    checkOutput("t2_drained", trace_valid, 0);

    // Store: retires without an RF write
    doReset();
    applyStimulus(1'b1, mk(32'h300, 1'b0, 5'd7, 32'hDEAD), 1'b1); tick();
    checkOutput("t4_rf_wen", WB_to_RF_bus[37], 0);
    checkOutput("t4_fw_valid", WB_fw_bus[37], 0);
    applyStimulus(1'b0, '0, 1'b1); tick();
    checkOutput("t4_cnts", {Valid_Inst_cnt, RF_Write_cnt}, {4'd1, 4'd0});

    // Reset while FIFO is loaded and WB stalled
    applyStimulus(1'b0, '0, 1'b0); doReset();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, jinst(k), 1'b0); tick();
    end
    applyStimulus(1'b0, '0, 1'b0); tick();
    checkOutput("t5_pre_ready", WB_ready, 0);
    doReset();
    checkOutput("t5_tvalid", trace_valid, 0);
    checkOutput("t5_ready", WB_ready, 1);
    checkOutput("t5_tdata", trace_data, 0);
    checkOutput("t5_cnts", {Valid_Inst_cnt, RF_Write_cnt, WB_Stall_cnt}, 0);

    // Sixteen commits wrap the 4-bit counters to zero
    applyStimulus(1'b0, '0, 1'b1); doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, mk(32'h400 + 32'(4 * k), 1'b1, 5'(k), 32'(k)), 1'b1); tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (6) tick();
    checkOutput("t6_vic_wrap", Valid_Inst_cnt, 0);
    checkOutput("t6_rfw_wrap", RF_Write_cnt, 0);

    // Randomized traffic with varying consumer pressure and occasional resets
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = $urandom_range(5, 95);
      ri = mk($urandom, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      applyStimulus($urandom_range(0, 99) < 70, ri, $urandom_range(0, 99) < bias);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
